// File: rtl/bp_clint_multicore.sv
// Core-local interruptor for num_core_p harts: per-core msip/mtimecmp, a shared prescaled mtime,
// and a one-request-in-flight bus port that has a one-cycle response latency.
module bp_clint_multicore #(
  parameter int unsigned num_core_p    = 2,
  parameter int unsigned paddr_width_p = 56,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned mtime_div_p   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic                     req_size_i,
  input  logic [data_width_p-1:0]  req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  output logic [num_core_p-1:0]    software_irq_o,
  output logic [num_core_p-1:0]    timer_irq_o
);

  localparam int unsigned    DivW     = (mtime_div_p > 1) ? $clog2(mtime_div_p) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(mtime_div_p - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StResp = 1'b1;

  localparam logic [23:0] MtimecmpOff = 24'h00_4000;
  localparam logic [23:0] MtimeOff    = 24'h00_bff8;

  logic [0:0]                   state_q, state_d;
  logic [63:0]                  resp_data_q, resp_data_d;
  logic                         resp_err_q, resp_err_d;
  logic [63:0]                  mtime_q, mtime_d;
  logic [DivW-1:0]              presc_q, presc_d;
  logic [num_core_p-1:0]        msip_q, msip_d;
  logic [num_core_p-1:0][63:0]  mtimecmp_q, mtimecmp_d;
  logic [num_core_p-1:0]        timer_irq_q, timer_irq_d;

  logic [23:0]           off;
  logic [20:0]           cmp_word;
  logic                  hit, misaligned, in_msip, in_cmp, in_mtime, upper;
  logic [num_core_p-1:0] msip_hit, cmp_hit;
  logic                  mtime_hit, dec_err, tick, do_wr;
  logic [63:0]           rd_data;

  function automatic logic [63:0] rd_sel(input logic [63:0] v, input logic size8,
                                         input logic hi);
    if (size8)   return v;
    else if (hi) return {32'b0, v[63:32]};
    else         return {32'b0, v[31:0]};
  endfunction

  // A 4B write replaces only the addressed half of the 64b register.
  function automatic logic [63:0] wr_merge(input logic [63:0] old, input logic [63:0] wd,
                                           input logic size8, input logic hi);
    if (size8)   return wd;
    else if (hi) return {wd[31:0], old[31:0]};
    else         return {old[63:32], wd[31:0]};
  endfunction

  assign off        = req_addr_i[23:0];
  assign cmp_word   = off[23:3] - MtimecmpOff[23:3];
  assign upper      = off[2];
  assign hit        = (req_addr_i[paddr_width_p-1:24] == (paddr_width_p-24)'(8'h02));
  assign misaligned = req_size_i ? (off[2:0] != 3'b000) : (off[1:0] != 2'b00);
  assign in_msip    = (off < MtimecmpOff);
  assign in_cmp     = (off >= MtimecmpOff) && (off < MtimeOff);
  assign in_mtime   = (off[23:3] == MtimeOff[23:3]);

  always_comb begin
    msip_hit  = '0;
    cmp_hit   = '0;
    rd_data   = '0;
    mtime_hit = hit && !misaligned && in_mtime;
    for (int i = 0; i < int'(num_core_p); i++) begin
      msip_hit[i] = hit && !misaligned && in_msip && !req_size_i && (off[23:2] == 22'(i));
      cmp_hit[i]  = hit && !misaligned && in_cmp && (cmp_word == 21'(i));
      if (msip_hit[i]) rd_data = {63'b0, msip_q[i]};
      if (cmp_hit[i])  rd_data = rd_sel(mtimecmp_q[i], req_size_i, upper);
    end
    if (mtime_hit) rd_data = rd_sel(mtime_q, req_size_i, upper);
    dec_err = !(|msip_hit || |cmp_hit || mtime_hit);
  end

  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    tick        = (presc_q == DivLast);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    do_wr       = (state_q == StIdle) && req_v_i && req_w_i && !dec_err;

    for (int i = 0; i < int'(num_core_p); i++) begin
      timer_irq_d[i] = (mtime_q >= mtimecmp_q[i]);
    end

    case (state_q)
      StIdle: begin
        if (req_v_i) begin
          state_d     = StResp;
          resp_err_d  = dec_err;
          resp_data_d = (req_w_i || dec_err) ? 64'd0 : rd_data;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A software mtime write overrides that cycle's tick; the prescaler keeps running.
    if (do_wr) begin
      for (int i = 0; i < int'(num_core_p); i++) begin
        if (msip_hit[i]) msip_d[i] = req_data_i[0];
        if (cmp_hit[i])  mtimecmp_d[i] = wr_merge(mtimecmp_q[i], req_data_i, req_size_i, upper);
      end
      if (mtime_hit) mtime_d = wr_merge(mtime_q, req_data_i, req_size_i, upper);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      mtime_q     <= '0;
      presc_q     <= '0;
      msip_q      <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= '0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      mtime_q     <= mtime_d;
      presc_q     <= presc_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign resp_v_o       = (state_q == StResp);
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign software_irq_o = msip_q;
  assign timer_irq_o    = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_multicore.sv
// Scoreboard bench for bp_clint_multicore: a register-level model predicts responses and
// interrupt lines; mtime is derived arithmetically from the clock-edge count.
module tb_bp_clint_multicore;

  localparam int NumCore = 2;
  localparam int Div     = 4;

  logic               clk = 1'b0;
  logic               reset_n_i = 1'b0;
  logic               req_v_i = 1'b0, req_w_i = 1'b0, req_size_i = 1'b0, resp_ready_i = 1'b0;
  logic [55:0]        req_addr_i = '0;
  logic [63:0]        req_data_i = '0;
  logic               req_ready_o, resp_v_o, resp_err_o;
  logic [63:0]        resp_data_o;
  logic [NumCore-1:0] software_irq_o, timer_irq_o;

  always #5 clk = ~clk;

  bp_clint_multicore #(
    .num_core_p   (NumCore),
    .paddr_width_p(56),
    .data_width_p (64),
    .mtime_div_p  (Div)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .req_v_i       (req_v_i),
    .req_ready_o   (req_ready_o),
    .req_w_i       (req_w_i),
    .req_addr_i    (req_addr_i),
    .req_size_i    (req_size_i),
    .req_data_i    (req_data_i),
    .resp_v_o      (resp_v_o),
    .resp_ready_i  (resp_ready_i),
    .resp_data_o   (resp_data_o),
    .resp_err_o    (resp_err_o),
    .software_irq_o(software_irq_o),
    .timer_irq_o   (timer_irq_o)
  );

  typedef struct packed {logic err; logic [63:0] data;} exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  // Edges seen since reset release; edge k ticks mtime when k is a multiple of Div.
  always @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) cyc <= 0;
    else            cyc <= cyc + 1;

  // Model: each register keeps its current value, previous value and the edge it changed on.
  logic [63:0] mt_base, mt_old_base;
  int          mt_edge, mt_old_edge;
  logic [63:0] cmp_cur [NumCore], cmp_old [NumCore];
  int          cmp_edge[NumCore];
  logic        msip_cur[NumCore], msip_old[NumCore];
  int          msip_edge[NumCore];

  function automatic void model_init();
    mt_base = '0; mt_old_base = '0; mt_edge = 0; mt_old_edge = 0;
    for (int i = 0; i < NumCore; i++) begin
      cmp_cur[i] = '1; cmp_old[i] = '1; cmp_edge[i] = 0;
      msip_cur[i] = 1'b0; msip_old[i] = 1'b0; msip_edge[i] = 0;
    end
  endfunction

  // Values held after edge k.
  function automatic logic [63:0] mtime_at(input int k);
    if (k >= mt_edge) return mt_base + 64'((k / Div) - (mt_edge / Div));
    return mt_old_base + 64'((k / Div) - (mt_old_edge / Div));
  endfunction
  function automatic logic [63:0] cmp_at(input int i, input int k);
    return (k >= cmp_edge[i]) ? cmp_cur[i] : cmp_old[i];
  endfunction
  function automatic logic msip_at(input int i, input int k);
    return (k >= msip_edge[i]) ? msip_cur[i] : msip_old[i];
  endfunction

  function automatic logic [63:0] pick(input logic [63:0] v, input logic size8, input logic hi);
    if (size8) return v;
    return hi ? {32'b0, v[63:32]} : {32'b0, v[31:0]};
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] wd,
                                        input logic size8, input logic hi);
    if (size8) return wd;
    return hi ? {wd[31:0], o[31:0]} : {o[63:32], wd[31:0]};
  endfunction

  // Predict the response to a request accepted on edge n and apply its write at edge n.
  function automatic void model_access(input logic w, input logic [55:0] addr, input logic size8,
                                       input logic [63:0] wd, input int n,
                                       output logic err, output logic [63:0] rd);
    int unsigned off;
    int          idx;
    int          k;
    logic [63:0] cur;
    k   = n - 1;
    err = 1'b1;
    rd  = '0;
    off = 32'(addr[23:0]);
    if (addr[55:24] != 32'h2) return;
    if (size8 ? (off % 8 != 0) : (off % 4 != 0)) return;
    if (off < 32'h4000) begin
      if (size8) return;
      idx = int'(off / 4);
      if (idx >= NumCore) return;
      err = 1'b0;
      if (w) begin
        msip_old[idx] = msip_at(idx, k); msip_cur[idx] = wd[0]; msip_edge[idx] = n;
      end else rd = {63'b0, msip_at(idx, k)};
    end else if (off < 32'hbff8) begin
      idx = int'((off - 32'h4000) / 8);
      if (idx >= NumCore) return;
      err = 1'b0;
      cur = cmp_at(idx, k);
      if (w) begin
        cmp_old[idx] = cur; cmp_cur[idx] = merge(cur, wd, size8, off % 8 == 4); cmp_edge[idx] = n;
      end else rd = pick(cur, size8, off % 8 == 4);
    end else if (off == 32'hbff8 || off == 32'hbffc) begin
      err = 1'b0;
      cur = mtime_at(k);
      if (w) begin
        mt_old_base = mt_base; mt_old_edge = mt_edge;
        mt_base = merge(cur, wd, size8, off == 32'hbffc); mt_edge = n;
      end else rd = pick(cur, size8, off == 32'hbffc);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Response monitor: compare whenever a response is handed off.
  exp_t e_mon;
  always @(negedge clk) begin
    if (reset_n_i && resp_v_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp: got data %h with nothing expected", resp_data_o);
      end else begin
        e_mon = exp_q.pop_front();
        check("resp_err", 64'(resp_err_o), 64'(e_mon.err));
        check("resp_data", resp_data_o, e_mon.data);
      end
    end
  end

  // Interrupt monitor, every cycle.
  logic [NumCore-1:0] exp_sw, exp_tm;
  always @(negedge clk) begin
    if (reset_n_i) begin
      for (int i = 0; i < NumCore; i++) begin
        if (cyc == 0) begin
          exp_sw[i] = 1'b0; exp_tm[i] = 1'b0;
        end else begin
          exp_sw[i] = msip_at(i, cyc);
          exp_tm[i] = (mtime_at(cyc - 1) >= cmp_at(i, cyc - 1));
        end
      end
      check("software_irq", 64'(software_irq_o), 64'(exp_sw));
      check("timer_irq", 64'(timer_irq_o), 64'(exp_tm));
    end
  end

  // Called in the drive slot (#1 after a rising edge).
  task automatic do_req(input logic w, input logic [55:0] addr, input logic size8,
                        input logic [63:0] wd, input int stall);
    exp_t e;
    logic ee;
    logic [63:0] ed;
    int waitc = 0;
    while (!req_ready_o && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    if (!req_ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 20 cycles");
      return;
    end
    model_access(w, addr, size8, wd, cyc + 1, ee, ed);
    e.err = ee; e.data = ed;
    exp_q.push_back(e);
    req_v_i = 1'b1; req_w_i = w; req_addr_i = addr; req_size_i = size8; req_data_i = wd;
    @(posedge clk); #1;
    req_v_i = 1'b0; req_data_i = $urandom(); req_addr_i = {24'b0, 32'($urandom())};
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_resp_v", 64'(resp_v_o), 64'd1);
      check("hold_req_ready", 64'(req_ready_o), 64'd0);
      check("hold_data", resp_data_o, ed);
      check("hold_err", 64'(resp_err_o), 64'(ee));
      @(posedge clk); #1;
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] pool[14] = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008, 32'h0200_4000,
                            32'h0200_4004, 32'h0200_4008, 32'h0200_400c, 32'h0200_4010,
                            32'h0200_bff8, 32'h0200_bffc, 32'h0200_bff0, 32'h0200_0002,
                            32'h0300_0000, 32'h0200_c000};

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] a;
    model_init();
    repeat (3) @(posedge clk);
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready_o), 64'd1);
    check("reset_resp_v", 64'(resp_v_o), 64'd0);
    check("reset_resp_data", resp_data_o, 64'd0);
    @(posedge clk); #1;

    do_req(1'b0, 56'h0200_4008, 1'b1, '0, 0);                 // mtimecmp[1] reset value
    do_req(1'b1, 56'h0200_0004, 1'b0, 64'hffff_ffff, 1);      // msip[1] <- 1
    do_req(1'b0, 56'h0200_0004, 1'b0, '0, 0);
    do_req(1'b1, 56'h0200_bff8, 1'b1, 64'hffff_ffff_ffff_fffe, 0);
    idle(8);
    do_req(1'b0, 56'h0200_bff8, 1'b1, '0, 0);                 // wrapped mtime
    do_req(1'b1, 56'h0200_bff8, 1'b1, 64'd0, 0);
    do_req(1'b1, 56'h0200_4000, 1'b1, 64'd10, 0);
    idle(60);
    do_req(1'b1, 56'h0200_4000, 1'b1, 64'd100, 0);            // clears timer_irq[0]
    idle(3);
    do_req(1'b1, 56'h0200_400c, 1'b0, 64'h1, 0);
    do_req(1'b0, 56'h0200_4008, 1'b1, '0, 2);                 // 0x1_ffff_ffff
    do_req(1'b0, 56'h0200_4010, 1'b1, '0, 0);                 // errors below
    do_req(1'b0, 56'h0200_0000, 1'b1, '0, 0);
    do_req(1'b0, 56'h0200_4002, 1'b0, '0, 0);
    do_req(1'b0, 56'h0300_0000, 1'b1, '0, 5);
    do_req(1'b1, 56'h0200_4010, 1'b1, 64'd5, 0);              // errored write, no effect
    do_req(1'b0, 56'h0200_bffc, 1'b0, '0, 0);
    do_req(1'b0, 56'h0200_bff8, 1'b0, '0, 0);

    for (int t = 0; t < 150; t++) begin
      a = {24'b0, pool[$urandom_range(13)]};
      if ($urandom_range(9) == 0) a[40] = 1'b1;
      do_req(1'($urandom_range(1)), a, 1'($urandom_range(1)),
             {32'($urandom()), ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : 32'($urandom())},
             $urandom_range(3));
      idle($urandom_range(2));
    end

    // Reset while a response is pending.
    model_access(1'b0, 56'h0200_bff8, 1'b1, '0, cyc + 1, e_mon.err, e_mon.data);
    req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 56'h0200_bff8; req_size_i = 1'b1;
    @(posedge clk); #1;
    req_v_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check("rst_resp_v", 64'(resp_v_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_sw_irq", 64'(software_irq_o), 64'd0);
    check("rst_tm_irq", 64'(timer_irq_o), 64'd0);
    check("rst_resp_data", resp_data_o, 64'd0);
    exp_q.delete();
    model_init();
    idle(2);
    reset_n_i = 1'b1;
    do_req(1'b0, 56'h0200_4000, 1'b1, '0, 0);
    do_req(1'b0, 56'h0200_0004, 1'b0, '0, 0);
    do_req(1'b0, 56'h0200_bff8, 1'b1, '0, 0);
    idle(2);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
